oled_num_display: RTL and testbench
===================================

OLED_NUM_DISPLAY -- requirements
Module: oled_num_display

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 30: binary input width.
- DIGITS, 9: displayed decimal digits, 1..16.
- BASE_X, 10: column of the most significant digit.
- BASE_Y, 2: page row.
- CHAR_PITCH, 8: column step per digit.
- LZ_BLANK, 1: enables leading-zero blanking.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the single clock; the block has one clock and reset is synchronous, active-high.
- reset, in, 1: synchronous, active-high.
- init_done, in, 1: panel initialisation complete (level).
- data, in, DATA_W: unsigned value to display.
- update, in, 1: refresh request.
- busy, out, 1: a frame is in progress.
- overflow, out, 1: the last accepted value does not fit in DIGITS digits.
- clear_start, out, 1: clear-screen request (level).
- clear_done, in, 1: clear acknowledge.
- write_start, out, 1: glyph-write request (level).
- write_data, out, 48: 6-column glyph, MSB byte first.
- set_pos_x, out, 8: glyph column.
- set_pos_y, out, 8: glyph page.
- write_done, in, 1: glyph-write acknowledge.
- frame_done, out, 1: one-cycle pulse when the frame completes.

Function
REQ-003 The state machine SHALL have states IDLE, CLEAR, CONVERT, LOAD, WRITE and DONE.

REQ-004 Leaving reset, the FSM SHALL take CLEAR exactly once, on the first cycle init_done=1. It SHALL hold clear_start=1 until clear_done=1 is sampled, then return to IDLE.

REQ-005 In IDLE with the first clear complete, update=1 SHALL latch data and go to CONVERT; busy SHALL be 1 from the next cycle.

REQ-006 CONVERT SHALL perform a sequential shift-add-3 binary-to-BCD conversion. It SHALL take exactly DATA_W cycles and produce 4*DIGITS BCD bits.

REQ-007 Any nonzero bit shifted out above the top BCD digit, or a top digit greater than 9, SHALL set overflow for that frame. overflow SHALL be cleared at the next accepted update.

REQ-008 LOAD (one cycle) SHALL compute the values for digit index i, where i=0 is the most significant digit:
- set_pos_x = BASE_X + i*CHAR_PITCH, truncated to 8 bits (wraps modulo 256).
- set_pos_y = BASE_Y.
- write_data = the glyph for digit i.

REQ-009 Glyph table (hex):
- 0 = 384444443800
- 1 = 00487C400000
- 2 = 486464544C00
- 3 = 28444C4C3400
- 4 = 1028247C2000
- 5 = 3C5454543400
- 6 = 385454543000
- 7 = 0C04740C0400
- 8 = 2C5454546C00
- 9 = 185454543800
- dash = 101010101000
- blank = 000000000000

REQ-010 With LZ_BLANK=1, zero digits above the first nonzero digit SHALL use the blank glyph. Digit DIGITS-1 SHALL always be drawn.

REQ-011 On overflow, every digit SHALL use the dash glyph.

REQ-012 In WRITE, write_start SHALL be 1 and position/data outputs SHALL be stable until write_done=1 is sampled. On the following cycle write_start SHALL be 0, and the FSM SHALL go to LOAD for i+1, or to DONE after i=DIGITS-1.

REQ-013 There SHALL be a minimum one-cycle write_start low gap between glyphs.

REQ-014 write_done or clear_done sampled while its request is 0 SHALL be ignored.

REQ-015 DONE SHALL pulse frame_done for one cycle, then go to IDLE; busy SHALL be 0 in IDLE.

REQ-016 update=1 while busy SHALL set a pending flag. Multiple requests SHALL coalesce into one.

REQ-017 If the pending flag is set, DONE SHALL go directly to CONVERT using data sampled in DONE, and SHALL clear the flag.

REQ-018 update=1 in the same cycle as DONE SHALL be treated as pending.

REQ-019 If init_done falls to 0, the block SHALL finish the current glyph handshake, then return to IDLE. The first-clear flag SHALL be re-armed, so CLEAR is taken again when init_done returns to 1.

REQ-020 Latency: update sampled at cycle t (in IDLE) SHALL give first write_start=1 at cycle t+DATA_W+2.

REQ-021 update SHALL be ignored before the first clear completes.

Reset
REQ-022 reset=1 at any clock edge, including mid-handshake, SHALL force on the next edge:
- state = IDLE.
- busy, overflow, clear_start, write_start, frame_done = 0.
- write_data, set_pos_x, set_pos_y = 0.
- pending flag and first-clear flag cleared.
- digit index = 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- init_done=1 after reset -> clear_start=1 until clear_done. Then update with data=1234, defaults -> glyphs blank x5, then 1,2,3,4 at x=10,18,...,74; frame_done once; overflow=0.
- data=0, LZ_BLANK=1 -> eight blanks, then glyph 0 at x=74.
- DIGITS=4, data=12345 -> overflow=1, four dash glyphs.
- update pulsed 3 times during a frame with the last data=7 -> exactly one further frame, showing 7; frame_done twice in total.
- reset asserted while write_start=1, before write_done -> all outputs 0 the next cycle. A later write_done is ignored. A new update is ignored until init_done is seen and the clear repeats.
- write_done held high continuously -> each glyph still shows a one-cycle write_start low gap; exactly DIGITS writes occur.

Source files
------------

// File: rtl/oled_num_display.sv
`default_nettype none
// ============================================================================
// Module      : oled_num_display
// Description : Converts an unsigned binary value to decimal and draws it on
//               an OLED panel as a row of 6-column glyphs, one handshake each.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_num_display #(
    parameter int DATA_W     = 30,
    parameter int DIGITS     = 9,
    parameter int BASE_X     = 10,
    parameter int BASE_Y     = 2,
    parameter int CHAR_PITCH = 8,
    parameter int LZ_BLANK   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_done,
    input  logic [DATA_W-1:0] data,
    input  logic              update,
    output logic              busy,
    output logic              overflow,
    output logic              clear_start,
    input  logic              clear_done,
    output logic              write_start,
    output logic [47:0]       write_data,
    output logic [7:0]        set_pos_x,
    output logic [7:0]        set_pos_y,
    input  logic              write_done,
    output logic              frame_done
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(DATA_W + 1);
    localparam int c_IDX_W = 4;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

    localparam logic [47:0] c_GLYPH_DASH  = 48'h101010101000;
    localparam logic [47:0] c_GLYPH_BLANK = 48'h000000000000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_CONVERT = 3'd2,
        S_LOAD    = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic                 r_clr_done;
    logic                 r_pending;
    logic                 r_overflow;
    logic                 r_nz;
    logic [DATA_W-1:0]    r_bin;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [47:0]          r_write_data;
    logic [7:0]           r_pos_x;
    logic [7:0]           r_pos_y;

    logic                 w_accept_idle;
    logic                 w_accept_done;
    logic                 w_accept;
    logic                 w_conv_last;
    logic [c_BCD_W-1:0]   w_bcd_adj;
    logic [c_BCD_W-1:0]   w_bcd_next;
    logic                 w_shift_out;
    logic [3:0]           w_top_digit;
    logic [3:0]           w_digit;
    logic                 w_blank;
    logic [47:0]          w_glyph;
    logic [7:0]           w_pos_x;

    function automatic logic [47:0] f_glyph(input logic [3:0] d);
        logic [47:0] g;
        case (d)
            4'd0:    g = 48'h384444443800;
            4'd1:    g = 48'h00487C400000;
            4'd2:    g = 48'h486464544C00;
            4'd3:    g = 48'h28444C4C3400;
            4'd4:    g = 48'h1028247C2000;
            4'd5:    g = 48'h3C5454543400;
            4'd6:    g = 48'h385454543000;
            4'd7:    g = 48'h0C04740C0400;
            4'd8:    g = 48'h2C5454546C00;
            4'd9:    g = 48'h185454543800;
            default: g = c_GLYPH_DASH;
        endcase
        return g;
    endfunction

    // A new frame starts from IDLE on a request, or straight out of DONE when
    // a request arrived during the previous frame.
    assign w_accept_idle = (r_state == S_IDLE) && r_clr_done && init_done && update;
    assign w_accept_done = (r_state == S_DONE) && init_done && (r_pending || update);
    assign w_accept      = w_accept_idle || w_accept_done;
    assign w_conv_last   = (r_state == S_CONVERT) && (r_cnt == c_CNT_LAST);

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    assign w_shift_out = w_bcd_adj[c_BCD_W-1];
    assign w_bcd_next  = {w_bcd_adj[c_BCD_W-2:0], r_bin[DATA_W-1]};
    assign w_top_digit = w_bcd_next[c_BCD_W-1 -: 4];

    // Digit index 0 is the most significant BCD nibble.
    always_comb begin
        w_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == c_IDX_W'(DIGITS - 1 - k)) begin
                w_digit = r_bcd[4*k +: 4];
            end
        end
    end

    assign w_blank = (LZ_BLANK != 0) && !r_nz && (w_digit == 4'd0) && (r_idx != c_IDX_LAST);
    assign w_pos_x = 8'(BASE_X) + 8'(r_idx) * 8'(CHAR_PITCH);

    always_comb begin
        if (r_overflow) begin
            w_glyph = c_GLYPH_DASH;
        end else if (w_blank) begin
            w_glyph = c_GLYPH_BLANK;
        end else begin
            w_glyph = f_glyph(w_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        clear_start  = 1'b0;
        write_start  = 1'b0;
        frame_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept_idle) begin
                    w_next_state = S_CONVERT;
                end else if (!r_clr_done && init_done) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clear_start = 1'b1;
                if (!init_done || clear_done) begin
                    w_next_state = S_IDLE;
                end
            end
            S_CONVERT: begin
                busy = 1'b1;
                if (!init_done) begin
                    w_next_state = S_IDLE;
                end else if (w_conv_last) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                busy         = 1'b1;
                w_next_state = init_done ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                busy        = 1'b1;
                write_start = 1'b1;
                // A panel shutdown only takes effect once the glyph in flight is acknowledged.
                if (write_done) begin
                    if (!init_done) begin
                        w_next_state = S_IDLE;
                    end else if (r_idx == c_IDX_LAST) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                frame_done   = 1'b1;
                w_next_state = w_accept_done ? S_CONVERT : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_done   <= 1'b0;
            r_pending    <= 1'b0;
            r_overflow   <= 1'b0;
            r_nz         <= 1'b0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_write_data <= '0;
            r_pos_x      <= '0;
            r_pos_y      <= '0;
        end else begin
            if (!init_done) begin
                r_clr_done <= 1'b0;
            end else if ((r_state == S_CLEAR) && clear_done) begin
                r_clr_done <= 1'b1;
            end

            if (w_accept || !init_done) begin
                r_pending <= 1'b0;
            end else if (busy && update) begin
                r_pending <= 1'b1;
            end

            if (w_accept) begin
                r_bin      <= data;
                r_bcd      <= '0;
                r_cnt      <= '0;
                r_overflow <= 1'b0;
                r_nz       <= 1'b0;
                r_idx      <= '0;
            end else if (r_state == S_CONVERT) begin
                r_bin <= r_bin << 1;
                r_bcd <= w_bcd_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_shift_out || (w_conv_last && (w_top_digit > 4'd9))) begin
                    r_overflow <= 1'b1;
                end
            end

            if (r_state == S_LOAD) begin
                r_write_data <= w_glyph;
                r_pos_x      <= w_pos_x;
                r_pos_y      <= 8'(BASE_Y);
                if (w_digit != 4'd0) begin
                    r_nz <= 1'b1;
                end
            end

            if ((r_state == S_WRITE) && write_done && (r_idx != c_IDX_LAST)) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign overflow   = r_overflow;
    assign write_data = r_write_data;
    assign set_pos_x  = r_pos_x;
    assign set_pos_y  = r_pos_y;

endmodule
`default_nettype wire

// File: tb/tb_oled_num_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_oled_num_display
// Description : Self-checking bench for oled_num_display against a decimal
//               reference model; drives a 9-digit and a 4-digit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_num_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic        update;
    logic        clear_done;
    logic        write_done;
    logic        sel;
    logic [29:0] data;

    logic        a_busy, a_overflow, a_clear_start, a_write_start, a_frame_done;
    logic [47:0] a_write_data;
    logic [7:0]  a_pos_x, a_pos_y;
    logic        b_busy, b_overflow, b_clear_start, b_write_start, b_frame_done;
    logic [47:0] b_write_data;
    logic [7:0]  b_pos_x, b_pos_y;

    logic        a_update, a_clear_done, a_write_done;
    logic        b_update, b_clear_done, b_write_done;

    logic        m_busy, m_overflow, m_clear_start, m_write_start, m_frame_done;
    logic [47:0] m_write_data;
    logic [7:0]  m_pos_x, m_pos_y;

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;

    localparam logic [47:0] c_DASH = 48'h101010101000;
    logic [47:0] glyph_tab [0:9] = '{
        48'h384444443800, 48'h00487C400000, 48'h486464544C00, 48'h28444C4C3400,
        48'h1028247C2000, 48'h3C5454543400, 48'h385454543000, 48'h0C04740C0400,
        48'h2C5454546C00, 48'h185454543800};

    logic [47:0] exp_g [16];
    bit          exp_ovf;

    always #5 clk = ~clk;

    assign a_update     = update & ~sel;
    assign b_update     = update & sel;
    assign a_clear_done = clear_done & ~sel;
    assign b_clear_done = clear_done & sel;
    assign a_write_done = write_done & ~sel;
    assign b_write_done = write_done & sel;

    assign m_busy        = sel ? b_busy        : a_busy;
    assign m_overflow    = sel ? b_overflow    : a_overflow;
    assign m_clear_start = sel ? b_clear_start : a_clear_start;
    assign m_write_start = sel ? b_write_start : a_write_start;
    assign m_frame_done  = sel ? b_frame_done  : a_frame_done;
    assign m_write_data  = sel ? b_write_data  : a_write_data;
    assign m_pos_x       = sel ? b_pos_x       : a_pos_x;
    assign m_pos_y       = sel ? b_pos_y       : a_pos_y;

    oled_num_display u_dut_a (
        .clk(clk), .reset(reset), .init_done(init_done), .data(data),
        .update(a_update), .busy(a_busy), .overflow(a_overflow),
        .clear_start(a_clear_start), .clear_done(a_clear_done),
        .write_start(a_write_start), .write_data(a_write_data),
        .set_pos_x(a_pos_x), .set_pos_y(a_pos_y),
        .write_done(a_write_done), .frame_done(a_frame_done)
    );

    oled_num_display #(.DATA_W(16), .DIGITS(4)) u_dut_b (
        .clk(clk), .reset(reset), .init_done(init_done), .data(data[15:0]),
        .update(b_update), .busy(b_busy), .overflow(b_overflow),
        .clear_start(b_clear_start), .clear_done(b_clear_done),
        .write_start(b_write_start), .write_data(b_write_data),
        .set_pos_x(b_pos_x), .set_pos_y(b_pos_y),
        .write_done(b_write_done), .frame_done(b_frame_done)
    );

    always @(posedge clk) begin
        if (m_frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference: decimal digits by division, then blanking / dash rules.
    task automatic build_exp(input longint v, input int nd);
        longint p;
        bit     seen;
        int     d;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        exp_ovf = (v >= p);
        seen = 0;
        for (int i = 0; i < nd; i++) begin
            p = p / 10;
            d = int'((v / p) % 10);
            if (exp_ovf) exp_g[i] = c_DASH;
            else if (d == 0 && !seen && i != nd - 1) exp_g[i] = 48'h0;
            else begin
                exp_g[i] = glyph_tab[d];
                seen = 1;
            end
        end
    endtask

    function automatic longint pick_value();
        longint p;
        case ($urandom_range(0, 3))
            0: return longint'($urandom_range(0, 99));
            1: return longint'($urandom_range(0, 999999999));
            2: return longint'($urandom_range(1000000000, 1073741823));
            default: begin
                p = 1;
                repeat ($urandom_range(0, 9)) p = p * 10;
                return p - longint'($urandom_range(0, 1));
            end
        endcase
    endfunction

    task automatic do_clear();
        int k = 0;
        while (!m_clear_start && k < 20) begin step(); k++; end
        chk("clr_req", m_clear_start, 1);
        repeat ($urandom_range(0, 2)) step();
        chk("clr_hold", m_clear_start, 1);
        clear_done = 1; step(); clear_done = 0;
        chk("clr_drop", m_clear_start, 0);
        chk("clr_busy", m_busy, 0);
    endtask

    task automatic run_frame(input longint v, input bit issue, input bit hold, input bit pend);
        int n, k, f0, nd, dw;
        nd = sel ? 4 : 9;
        dw = sel ? 16 : 30;
        build_exp(v, nd);
        f0 = fd_cnt;
        if (hold) write_done = 1;
        n = 0;
        if (issue) begin
            data = 30'(v); update = 1; step(); update = 0; n = 1;
        end
        for (int i = 0; i < nd; i++) begin
            k = 0;
            while (!m_write_start && k < 200) begin step(); k++; n++; end
            chk("ws_seen", m_write_start, 1);
            if (i == 0 && issue) chk("latency", n, dw + 2);
            chk("pos_x", m_pos_x, 8'(10 + i * 8));
            chk("pos_y", m_pos_y, 8'd2);
            chk("glyph", m_write_data, exp_g[i]);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) step();
                if (pend && i >= 1 && i <= 3) begin
                    data = (i == 3) ? 30'd7 : 30'($urandom_range(0, 999999));
                    update = 1; step(); update = 0;
                end
                chk("ws_hold", m_write_start, 1);
                chk("glyph_stable", m_write_data, exp_g[i]);
                write_done = 1;
            end
            step();
            if (!hold) write_done = 0;
            chk("ws_gap", m_write_start, 0);
        end
        chk("frame_done", m_frame_done, 1);
        chk("overflow", m_overflow, exp_ovf);
        step();
        write_done = 0;
        chk("frame_done_pulse", m_frame_done, 0);
        chk("busy_after", m_busy, pend);
        chk("frame_count", fd_cnt - f0, 1);
    endtask

    initial begin
        int k, f;
        reset = 1; init_done = 0; update = 0; clear_done = 0; write_done = 0;
        sel = 0; data = '0;
        repeat (3) step();
        reset = 0;
        step();
        chk("rst_busy", m_busy, 0);
        chk("rst_ovf", m_overflow, 0);
        chk("rst_clr", m_clear_start, 0);
        chk("rst_ws", m_write_start, 0);
        chk("rst_fd", m_frame_done, 0);
        chk("rst_wdata", m_write_data, 0);
        chk("rst_px", m_pos_x, 0);
        chk("rst_py", m_pos_y, 0);

        data = 30'd5; update = 1; step(); update = 0; step();
        chk("upd_pre_init", m_busy, 0);
        init_done = 1; step();
        chk("clr_first", m_clear_start, 1);
        do_clear();
        sel = 1; do_clear(); sel = 0;

        run_frame(1234, 1, 0, 0);
        run_frame(0, 1, 0, 0);

        f = fd_cnt;
        run_frame(555, 1, 0, 1);
        run_frame(7, 0, 0, 0);
        chk("pend_frames", fd_cnt - f, 2);

        run_frame(longint'($urandom_range(0, 999999)), 1, 1, 0);
        for (int r = 0; r < 10; r++) run_frame(pick_value(), 1, 1'($urandom_range(0, 1)), 0);

        sel = 1;
        run_frame(12345, 1, 0, 0);
        for (int r = 0; r < 4; r++)
            run_frame(longint'($urandom_range(0, 65535)), 1, 1'($urandom_range(0, 1)), 0);
        sel = 0;

        // Reset in the middle of a glyph handshake.
        data = 30'd1073741823; update = 1; step(); update = 0;
        k = 0;
        while (!m_write_start && k < 100) begin step(); k++; end
        chk("rm_ws", m_write_start, 1);
        reset = 1; step(); reset = 0;
        chk("rm_ws0", m_write_start, 0);
        chk("rm_busy", m_busy, 0);
        chk("rm_clr", m_clear_start, 0);
        chk("rm_fd", m_frame_done, 0);
        chk("rm_ovf", m_overflow, 0);
        chk("rm_wdata", m_write_data, 0);
        chk("rm_px", m_pos_x, 0);
        chk("rm_py", m_pos_y, 0);
        write_done = 1; step(); write_done = 0;
        chk("rm_reclr", m_clear_start, 1);
        chk("rm_wd_ign", m_write_start, 0);
        update = 1; step(); update = 0; step();
        chk("rm_upd_ign", m_busy, 0);
        do_clear();
        step();
        chk("rm_nopend", m_busy, 0);
        sel = 1; do_clear(); sel = 0;
        run_frame(pick_value(), 1, 0, 0);

        // Panel drops init mid-glyph.
        data = 30'd4321; update = 1; step(); update = 0;
        k = 0;
        while (!m_write_start && k < 100) begin step(); k++; end
        chk("id_ws", m_write_start, 1);
        init_done = 0; step(); step();
        chk("id_hold", m_write_start, 1);
        write_done = 1; step(); write_done = 0;
        chk("id_ws_drop", m_write_start, 0);
        chk("id_busy", m_busy, 0);
        init_done = 1; step();
        chk("id_reclr", m_clear_start, 1);
        do_clear();
        sel = 1; do_clear(); sel = 0;
        run_frame(pick_value(), 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
